// File: rtl/pll_dco_pkg.sv
// Shared types, defaults and code decoding for the 1x PLL digitally controlled oscillator.
package pll_dco_pkg;

    localparam int DCO_AW         = 16;
    localparam int DCO_FW         = 12;
    localparam int DCO_F_INIT     = 'h100;
    localparam int DCO_F_MIN      = 'h020;
    localparam int DCO_F_MAX      = 'h7FF;
    localparam int DCO_STEP_FAST  = 16;
    localparam int DCO_STEP_FINE  = 1;
    localparam int DCO_LOCK_CNT   = 8;
    localparam int DCO_UNLOCK_CNT = 4;

    typedef enum logic [1:0] {
        ACQUIRE = 2'd0,
        TRACK   = 2'd1,
        LOCKED  = 2'd2
    } dco_state_e;

    localparam logic [1:0] ADJ_UP   = 2'b11;
    localparam logic [1:0] ADJ_DN   = 2'b00;
    localparam logic [1:0] ADJ_HOLD = 2'b01;
    localparam logic [1:0] ADJ_ILL  = 2'b10;

    typedef struct packed {
        logic up;
        logic dn;
        logic hold;
        logic ill;
    } adj_dec_t;

    function automatic adj_dec_t adj_decode(input logic [1:0] code);
        adj_dec_t d;
        d = '0;
        unique case (code)
            ADJ_UP:   d.up   = 1'b1;
            ADJ_DN:   d.dn   = 1'b1;
            ADJ_HOLD: d.hold = 1'b1;
            default:  d.ill  = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/pll_dco_ctrl.sv
// Update-strobe control: frequency word stepping with saturation, lock FSM and its counters.
module pll_dco_ctrl
    import pll_dco_pkg::*;
#(
    parameter int            FW         = DCO_FW,
    parameter logic [FW-1:0] F_INIT     = FW'(DCO_F_INIT),
    parameter logic [FW-1:0] F_MIN      = FW'(DCO_F_MIN),
    parameter logic [FW-1:0] F_MAX      = FW'(DCO_F_MAX),
    parameter int            STEP_FAST  = DCO_STEP_FAST,
    parameter int            STEP_FINE  = DCO_STEP_FINE,
    parameter int            LOCK_CNT   = DCO_LOCK_CNT,
    parameter int            UNLOCK_CNT = DCO_UNLOCK_CNT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          update,
    input  logic [1:0]    code,
    output logic [FW-1:0] freq_word,
    output logic          locked,
    output dco_state_e    state,
    output logic          clamp_hit,
    output logic          illegal_code
);

    localparam int HW = $clog2(LOCK_CNT + 1);
    localparam int UW = $clog2(UNLOCK_CNT + 1);

    localparam logic [HW-1:0] LOCK_N   = HW'(LOCK_CNT);
    localparam logic [UW-1:0] UNLOCK_N = UW'(UNLOCK_CNT);
    localparam logic [FW:0]   STEP_F   = (FW+1)'(STEP_FAST);
    localparam logic [FW:0]   STEP_S   = (FW+1)'(STEP_FINE);

    dco_state_e    state_q, state_d;
    logic [FW-1:0] fw_q, fw_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [UW-1:0] same_q, same_d;
    logic          dir_q, dir_d;
    logic          has_dir_q, has_dir_d;
    logic          locked_q, locked_d;
    logic          clamp_q, clamp_d;
    logic          ill_q, ill_d;

    adj_dec_t      dec;
    logic          move;
    logic          reversal;
    logic [FW:0]   step;
    logic [FW:0]   fw_ext;
    logic [FW:0]   sum;
    logic [HW-1:0] hold_inc;
    logic [UW-1:0] same_inc;

    always_comb begin
        dec      = adj_decode(code);
        move     = dec.up | dec.dn;
        step     = (state_q == ACQUIRE) ? STEP_F : STEP_S;
        fw_ext   = {1'b0, fw_q};
        sum      = dec.up ? (fw_ext + step) : (fw_ext - step);
        reversal = has_dir_q && ((dec.up && !dir_q) || (dec.dn && dir_q));
        hold_inc = (hold_q == LOCK_N) ? hold_q : hold_q + 1'b1;
        same_inc = (same_q == UNLOCK_N) ? same_q : same_q + 1'b1;
    end

    always_comb begin
        state_d   = state_q;
        fw_d      = fw_q;
        hold_d    = hold_q;
        same_d    = same_q;
        dir_d     = dir_q;
        has_dir_d = has_dir_q;
        clamp_d   = 1'b0;
        ill_d     = 1'b0;

        if (update) begin
            if (move) begin
                dir_d     = dec.up;
                has_dir_d = 1'b1;
                hold_d    = '0;
                // Down-step underflow shows up as the extra carry bit.
                if (dec.dn && (sum[FW] || sum < {1'b0, F_MIN})) begin
                    fw_d    = F_MIN;
                    clamp_d = 1'b1;
                end else if (dec.up && sum > {1'b0, F_MAX}) begin
                    fw_d    = F_MAX;
                    clamp_d = 1'b1;
                end else begin
                    fw_d = sum[FW-1:0];
                end
            end

            if (dec.hold) begin
                hold_d = hold_inc;
                same_d = '0;
            end

            ill_d = dec.ill;

            unique case (state_q)
                ACQUIRE: begin
                    if (reversal) begin
                        state_d = TRACK;
                    end else if (dec.hold && hold_inc == LOCK_N) begin
                        state_d = LOCKED;
                    end
                end
                TRACK: begin
                    if (dec.hold && hold_inc == LOCK_N) begin
                        state_d = LOCKED;
                    end
                end
                LOCKED: begin
                    if (move) begin
                        if (same_q != '0 && reversal) begin
                            state_d = TRACK;
                        end else if (same_inc == UNLOCK_N) begin
                            state_d = ACQUIRE;
                        end else begin
                            same_d = same_inc;
                        end
                    end
                end
                default: state_d = ACQUIRE;
            endcase

            // Every state entry starts with fresh run counters.
            if (state_d != state_q) begin
                hold_d = '0;
                same_d = '0;
            end
        end

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ACQUIRE;
            fw_q      <= F_INIT;
            hold_q    <= '0;
            same_q    <= '0;
            dir_q     <= 1'b0;
            has_dir_q <= 1'b0;
            locked_q  <= 1'b0;
            clamp_q   <= 1'b0;
            ill_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            fw_q      <= fw_d;
            hold_q    <= hold_d;
            same_q    <= same_d;
            dir_q     <= dir_d;
            has_dir_q <= has_dir_d;
            locked_q  <= locked_d;
            clamp_q   <= clamp_d;
            ill_q     <= ill_d;
        end
    end

    assign freq_word    = fw_q;
    assign locked       = locked_q;
    assign state        = state_q;
    assign clamp_hit    = clamp_q;
    assign illegal_code = ill_q;

endmodule

// File: rtl/pll_dco_1x.sv
// 1x PLL DCO: code synchronizer, phase-accumulator NCO and update strobe around pll_dco_ctrl.
module pll_dco_1x
    import pll_dco_pkg::*;
#(
    parameter int            AW         = DCO_AW,
    parameter int            FW         = DCO_FW,
    parameter logic [FW-1:0] F_INIT     = FW'(DCO_F_INIT),
    parameter logic [FW-1:0] F_MIN      = FW'(DCO_F_MIN),
    parameter logic [FW-1:0] F_MAX      = FW'(DCO_F_MAX),
    parameter int            STEP_FAST  = DCO_STEP_FAST,
    parameter int            STEP_FINE  = DCO_STEP_FINE,
    parameter int            LOCK_CNT   = DCO_LOCK_CNT,
    parameter int            UNLOCK_CNT = DCO_UNLOCK_CNT
) (
    input  logic          ClockIn,
    input  logic          ResetN,
    input  logic [1:0]    AdjustFreq,
    output logic          PLLClock,
    output logic [FW-1:0] FreqWord,
    output logic          Locked,
    output logic [1:0]    DcoState,
    output logic          ClampHit,
    output logic          IllegalCode
);

    logic [1:0]    sync1_q, sync1_d;
    logic [1:0]    sync2_q, sync2_d;
    logic [AW-1:0] acc_q, acc_d;
    logic          pll_q, pll_d;
    logic          pll_prev_q, pll_prev_d;
    logic          update;
    dco_state_e    state;

    always_comb begin
        sync1_d    = AdjustFreq;
        sync2_d    = sync1_q;
        acc_d      = acc_q + {{(AW-FW){1'b0}}, FreqWord};
        pll_d      = acc_q[AW-1];
        pll_prev_d = pll_q;
    end

    // Sync flops rest on the hold code so reset never looks like a step.
    always_ff @(posedge ClockIn or negedge ResetN) begin
        if (!ResetN) begin
            sync1_q    <= ADJ_HOLD;
            sync2_q    <= ADJ_HOLD;
            acc_q      <= '0;
            pll_q      <= 1'b0;
            pll_prev_q <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            acc_q      <= acc_d;
            pll_q      <= pll_d;
            pll_prev_q <= pll_prev_d;
        end
    end

    assign update = pll_q & ~pll_prev_q;

    pll_dco_ctrl #(
        .FW         (FW),
        .F_INIT     (F_INIT),
        .F_MIN      (F_MIN),
        .F_MAX      (F_MAX),
        .STEP_FAST  (STEP_FAST),
        .STEP_FINE  (STEP_FINE),
        .LOCK_CNT   (LOCK_CNT),
        .UNLOCK_CNT (UNLOCK_CNT)
    ) u_ctrl (
        .clk          (ClockIn),
        .rst_n        (ResetN),
        .update       (update),
        .code         (sync2_q),
        .freq_word    (FreqWord),
        .locked       (Locked),
        .state        (state),
        .clamp_hit    (ClampHit),
        .illegal_code (IllegalCode)
    );

    assign PLLClock = pll_q;
    assign DcoState = state;

endmodule

// File: tb/tb_pll_dco_1x.sv
// Scenario bench for pll_dco_1x: expected per-update results are queued and popped at each update.
module tb_pll_dco_1x;
    import pll_dco_pkg::*;

    logic        ClockIn = 1'b0;
    logic        ResetN = 1'b0;
    logic [1:0]  AdjustFreq = ADJ_HOLD;
    logic        PLLClock;
    logic [11:0] FreqWord;
    logic        Locked;
    logic [1:0]  DcoState;
    logic        ClampHit;
    logic        IllegalCode;

    int checks = 0;
    int errors = 0;
    int fw_m;

    typedef struct packed {
        logic [11:0] fw;
        logic [1:0]  st;
        logic        lk;
        logic        cl;
        logic        il;
    } obs_t;

    obs_t sbq[$];

    pll_dco_1x dut (
        .ClockIn     (ClockIn),
        .ResetN      (ResetN),
        .AdjustFreq  (AdjustFreq),
        .PLLClock    (PLLClock),
        .FreqWord    (FreqWord),
        .Locked      (Locked),
        .DcoState    (DcoState),
        .ClampHit    (ClampHit),
        .IllegalCode (IllegalCode)
    );

    always #5 ClockIn = ~ClockIn;

    function automatic obs_t mk(input int fw, input logic [1:0] st,
                                input logic cl, input logic il);
        obs_t e;
        e.fw = fw[11:0];
        e.st = st;
        e.lk = (st == 2'd2);
        e.cl = cl;
        e.il = il;
        return e;
    endfunction

    task automatic apply_reset;
        ResetN = 1'b0;
        AdjustFreq = ADJ_HOLD;
        sbq.delete();
        repeat (3) @(posedge ClockIn);
        @(negedge ClockIn);
        ResetN = 1'b1;
    endtask

    // Waits for a PLLClock rise, then samples one cycle later when the update has landed.
    task automatic wait_update(output obs_t o);
        logic prev;
        bit   found;
        prev = PLLClock;
        found = 0;
        for (int i = 0; i < 5000 && !found; i++) begin
            @(posedge ClockIn);
            #1;
            if (!prev && PLLClock) found = 1;
            prev = PLLClock;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL update_timeout got=no PLLClock rise exp=rise within 5000 cycles");
        end else begin
            @(posedge ClockIn);
            #1;
        end
        o.fw = FreqWord;
        o.st = DcoState;
        o.lk = Locked;
        o.cl = ClampHit;
        o.il = IllegalCode;
    endtask

    task automatic test_reset;
        logic [17:0] got;
        logic [17:0] exp;
        ResetN = 1'b0;
        AdjustFreq = ADJ_HOLD;
        repeat (2) @(posedge ClockIn);
        #1;
        exp = {1'b0, 12'h100, 1'b0, 2'b00, 1'b0, 1'b0};
        got = {PLLClock, FreqWord, Locked, DcoState, ClampHit, IllegalCode};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL reset_values got=%h exp=%h", got, exp);
        end
        @(negedge ClockIn);
        ResetN = 1'b1;
        repeat (10) @(posedge ClockIn);
        #1;
        got = {PLLClock, FreqWord, Locked, DcoState, ClampHit, IllegalCode};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL post_reset_idle got=%h exp=%h", got, exp);
        end
    endtask

    task automatic test_hold;
        obs_t o, e;
        logic prev;
        bit   found;
        int   lo, hi;
        apply_reset();
        for (int i = 1; i <= 8; i++) begin
            sbq.push_back(mk('h100, (i == 8) ? 2'd2 : 2'd0, 1'b0, 1'b0));
            wait_update(o);
            e = sbq.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL hold_upd%0d got=%h exp=%h", i, o, e);
            end
        end
        prev = PLLClock;
        found = 0;
        for (int i = 0; i < 600 && !found; i++) begin
            @(posedge ClockIn);
            #1;
            if (prev && !PLLClock) found = 1;
            prev = PLLClock;
        end
        lo = 1;
        for (int i = 0; i < 600; i++) begin
            @(posedge ClockIn);
            #1;
            if (PLLClock) break;
            lo++;
        end
        hi = 1;
        for (int i = 0; i < 600; i++) begin
            @(posedge ClockIn);
            #1;
            if (!PLLClock) break;
            hi++;
        end
        checks++;
        if (lo !== 128) begin
            errors++;
            $display("FAIL pll_low_cycles got=%0d exp=128", lo);
        end
        checks++;
        if (hi !== 128) begin
            errors++;
            $display("FAIL pll_high_cycles got=%0d exp=128", hi);
        end
    endtask

    task automatic test_acquire;
        obs_t o, e;
        apply_reset();
        fw_m = 'h100;
        AdjustFreq = ADJ_UP;
        for (int i = 1; i <= 4; i++) begin
            fw_m += 16;
            sbq.push_back(mk(fw_m, 2'd0, 1'b0, 1'b0));
            wait_update(o);
            e = sbq.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL acq_up%0d got=%h exp=%h", i, o, e);
            end
        end
        AdjustFreq = ADJ_DN;
        for (int i = 1; i <= 3; i++) begin
            fw_m -= (i == 1) ? 16 : 1;
            sbq.push_back(mk(fw_m, 2'd1, 1'b0, 1'b0));
            wait_update(o);
            e = sbq.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL acq_overshoot%0d got=%h exp=%h", i, o, e);
            end
        end
    endtask

    task automatic test_track_lock;
        obs_t o, e;
        for (int i = 1; i <= 16; i++) begin
            AdjustFreq = (i == 8) ? ADJ_UP : ADJ_HOLD;
            if (i == 8) fw_m += 1;
            sbq.push_back(mk(fw_m, (i == 16) ? 2'd2 : 2'd1, 1'b0, 1'b0));
            wait_update(o);
            e = sbq.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL track_upd%0d got=%h exp=%h", i, o, e);
            end
        end
    endtask

    task automatic test_unlock;
        obs_t       o, e;
        logic [1:0] cs [7];
        logic [1:0] ss [7];
        AdjustFreq = ADJ_DN;
        for (int i = 1; i <= 4; i++) begin
            fw_m -= 1;
            sbq.push_back(mk(fw_m, (i == 4) ? 2'd0 : 2'd2, 1'b0, 1'b0));
            wait_update(o);
            e = sbq.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL unlock_dn%0d got=%h exp=%h", i, o, e);
            end
        end
        AdjustFreq = ADJ_UP;
        fw_m += 16;
        sbq.push_back(mk(fw_m, 2'd1, 1'b0, 1'b0));
        wait_update(o);
        e = sbq.pop_front();
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL reacquire_rev got=%h exp=%h", o, e);
        end
        AdjustFreq = ADJ_HOLD;
        for (int i = 1; i <= 8; i++) begin
            sbq.push_back(mk(fw_m, (i == 8) ? 2'd2 : 2'd1, 1'b0, 1'b0));
            wait_update(o);
            e = sbq.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL relock_upd%0d got=%h exp=%h", i, o, e);
            end
        end
        cs = '{ADJ_UP, ADJ_UP, ADJ_HOLD, ADJ_UP, ADJ_UP, ADJ_UP, ADJ_DN};
        ss = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};
        for (int i = 0; i < 7; i++) begin
            AdjustFreq = cs[i];
            if (cs[i] == ADJ_UP) fw_m += 1;
            if (cs[i] == ADJ_DN) fw_m -= 1;
            sbq.push_back(mk(fw_m, ss[i], 1'b0, 1'b0));
            wait_update(o);
            e = sbq.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL locked_seq%0d got=%h exp=%h", i, o, e);
            end
        end
    endtask

    task automatic test_clamp;
        obs_t o, e;
        int   nxt;
        logic cl;
        for (int pass = 0; pass < 2; pass++) begin
            apply_reset();
            fw_m = 'h100;
            AdjustFreq = (pass == 0) ? ADJ_UP : ADJ_DN;
            for (int i = 1; i <= ((pass == 0) ? 113 : 15); i++) begin
                nxt = (pass == 0) ? fw_m + 16 : fw_m - 16;
                cl = (nxt > 'h7FF) || (nxt < 'h020);
                fw_m = (nxt > 'h7FF) ? 'h7FF : (nxt < 'h020) ? 'h020 : nxt;
                sbq.push_back(mk(fw_m, 2'd0, cl, 1'b0));
                wait_update(o);
                e = sbq.pop_front();
                checks++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL clamp_p%0d_upd%0d got=%h exp=%h", pass, i, o, e);
                end
                if (cl) begin
                    @(posedge ClockIn);
                    #1;
                    checks++;
                    if (ClampHit !== 1'b0) begin
                        errors++;
                        $display("FAIL clamp_pulse_width got=%b exp=0", ClampHit);
                    end
                end
            end
        end
    endtask

    task automatic test_illegal;
        obs_t        o, e;
        logic [17:0] got;
        logic [17:0] exp;
        apply_reset();
        for (int i = 1; i <= 10; i++) begin
            AdjustFreq = (i == 4) ? ADJ_ILL : (i == 10) ? ADJ_UP : ADJ_HOLD;
            sbq.push_back(mk((i == 10) ? 'h101 : 'h100, (i >= 9) ? 2'd2 : 2'd0,
                             1'b0, (i == 4)));
            wait_update(o);
            e = sbq.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL illegal_upd%0d got=%h exp=%h", i, o, e);
            end
            if (i == 4) begin
                @(posedge ClockIn);
                #1;
                checks++;
                if (IllegalCode !== 1'b0) begin
                    errors++;
                    $display("FAIL illegal_pulse_width got=%b exp=0", IllegalCode);
                end
            end
        end
        @(posedge ClockIn);
        #3;
        ResetN = 1'b0;
        #1;
        exp = {1'b0, 12'h100, 1'b0, 2'b00, 1'b0, 1'b0};
        got = {PLLClock, FreqWord, Locked, DcoState, ClampHit, IllegalCode};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL midrun_reset got=%h exp=%h", got, exp);
        end
        @(negedge ClockIn);
        ResetN = 1'b1;
    endtask

    initial begin
        test_reset();
        test_hold();
        test_acquire();
        test_track_lock();
        test_unlock();
        test_clamp();
        test_illegal();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
